// File: rtl/lsu_pipe.sv
// Load/store pipeline stage between EX and WB: issues aligned memory accesses,
// traps misaligned ones, aborts accesses that wait too long, and retires every
// instruction into the WB registers.
module lsu_pipe #(
  parameter int unsigned TIMEOUT     = 16,
  parameter bit          CHECK_ALIGN = 1'b1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [31:0]       pc_from_ex,
  input  logic [31:0]       b,
  input  logic [31:0]       c,
  input  logic [4:0]        rd_from_ex,
  input  logic              data_mem_access_ready_n,
  input  logic [31:0]       data_from_mem,
  output logic [ADDR_W-1:0] data_mem_addr,
  output logic              require_mem_access,
  output logic              write,
  output logic [1:0]        size,
  output logic [31:0]       data_to_mem,
  output logic              valid_to_wb,
  output logic [31:0]       pc_to_wb,
  output logic [4:0]        rd_to_wb,
  output logic [6:0]        opcode_to_wb,
  output logic [31:0]       c_to_wb,
  output logic [31:0]       d,
  output logic              misaligned,
  output logic              bus_err,
  output logic              stall
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned RD_W  = 5;
  localparam int unsigned CNT_W = 8;

  localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_nxt;
  logic              timeout_hit;

  logic [OP_W-1:0]   op_q;
  logic [F3_W-1:0]   f3_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   c_q;
  logic [RD_W-1:0]   rd_q;

  logic              in_is_store;
  logic              in_is_mem;
  logic              in_misaligned;
  logic              accept_mem;
  logic [1:0]        in_size;
  logic [XLEN-1:0]   in_store_data;

  logic [XLEN-1:0]   ld_shifted;
  logic [XLEN-1:0]   ld_data;

  // Decode the EX instruction: class, alignment, size code and lane-replicated store data
  always_comb begin
    in_is_store   = (opcode == OP_STORE);
    in_is_mem     = (opcode == OP_LOAD) || in_is_store;
    in_misaligned = 1'b0;
    in_size       = 2'b00;
    in_store_data = b;
    case (funct3[1:0])
      2'b00: begin
        in_size       = 2'b10;
        in_store_data = {4{b[7:0]}};
      end
      2'b01: begin
        in_size       = 2'b01;
        in_misaligned = c[0];
        in_store_data = {2{b[15:0]}};
      end
      default: begin
        in_size       = 2'b00;
        in_misaligned = |c[1:0];
        in_store_data = b;
      end
    endcase
    in_misaligned = CHECK_ALIGN && in_misaligned;
    accept_mem    = (state == IDLE) && valid_in && in_is_mem && !in_misaligned;
  end

  // Align returned data to bit 0 and extend it according to the load format
  always_comb begin
    ld_shifted = data_from_mem >> {c_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b100:  ld_data = {24'd0, ld_shifted[7:0]};
      3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b101:  ld_data = {16'd0, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

  // Wait-cycle bookkeeping: the access is abandoned on its TIMEOUT-th not-ready cycle
  assign wait_nxt    = wait_cnt + CNT_W'(1);
  assign timeout_hit = (wait_nxt == CNT_W'(TIMEOUT));

  // EX holds while an access is in flight and in the cycle one is being accepted
  assign stall = (state == BUSY) || (rst_n && accept_mem);

  // Pipeline FSM: capture, issue, complete or abort, and retire into WB registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      wait_cnt           <= '0;
      op_q               <= '0;
      f3_q               <= '0;
      pc_q               <= '0;
      c_q                <= '0;
      rd_q               <= '0;
      data_mem_addr      <= '0;
      require_mem_access <= 1'b0;
      write              <= 1'b0;
      size               <= '0;
      data_to_mem        <= '0;
      valid_to_wb        <= 1'b0;
      pc_to_wb           <= '0;
      rd_to_wb           <= '0;
      opcode_to_wb       <= '0;
      c_to_wb            <= '0;
      d                  <= '0;
      misaligned         <= 1'b0;
      bus_err            <= 1'b0;
    end else begin
      valid_to_wb <= 1'b0;
      misaligned  <= 1'b0;
      bus_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            op_q <= opcode;
            f3_q <= funct3;
            pc_q <= pc_from_ex;
            c_q  <= c;
            rd_q <= rd_from_ex;
            if (in_is_mem && !in_misaligned) begin
              state              <= BUSY;
              wait_cnt           <= '0;
              require_mem_access <= 1'b1;
              data_mem_addr      <= c[ADDR_W-1:0];
              write              <= in_is_store;
              size               <= in_size;
              data_to_mem        <= in_store_data;
            end else begin
              valid_to_wb  <= 1'b1;
              pc_to_wb     <= pc_from_ex;
              rd_to_wb     <= rd_from_ex;
              opcode_to_wb <= opcode;
              c_to_wb      <= c;
              if (in_is_mem) begin
                misaligned <= 1'b1;
                d          <= '0;
              end
            end
          end
        end
        BUSY: begin
          if (!data_mem_access_ready_n || timeout_hit) begin
            state              <= IDLE;
            wait_cnt           <= '0;
            require_mem_access <= 1'b0;
            valid_to_wb        <= 1'b1;
            pc_to_wb           <= pc_q;
            rd_to_wb           <= rd_q;
            opcode_to_wb       <= op_q;
            c_to_wb            <= c_q;
            if (!data_mem_access_ready_n) begin
              if (op_q == OP_LOAD) begin
                d <= ld_data;
              end
            end else begin
              bus_err <= 1'b1;
              d       <= '0;
            end
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_pipe.sv
// Self-checking bench for lsu_pipe: directed scenarios plus randomized traffic
// checked against a behavioural model of retirement, latency and data.
module tb_lsu_pipe;

  localparam int unsigned TMO = 4;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] pc_from_ex;
  logic [31:0] b;
  logic [31:0] c;
  logic [4:0]  rd_from_ex;
  logic        data_mem_access_ready_n;
  logic [31:0] data_from_mem;
  logic [31:0] data_mem_addr;
  logic        require_mem_access;
  logic        write;
  logic [1:0]  size;
  logic [31:0] data_to_mem;
  logic        valid_to_wb;
  logic [31:0] pc_to_wb;
  logic [4:0]  rd_to_wb;
  logic [6:0]  opcode_to_wb;
  logic [31:0] c_to_wb;
  logic [31:0] d;
  logic        misaligned;
  logic        bus_err;
  logic        stall;

  int checks;
  int errors;

  // observations collected by do_access
  int          obs_lat;
  int          obs_stall_cnt;
  int          obs_req_cnt;
  logic        obs_write;
  logic [1:0]  obs_size;
  logic [31:0] obs_dtm;
  logic [31:0] obs_addr;
  logic [31:0] obs_pc;
  logic [4:0]  obs_rd;
  logic [6:0]  obs_op;
  logic [31:0] obs_c;
  logic [31:0] obs_d;
  logic        obs_mis;
  logic        obs_berr;
  logic        obs_v_next;
  logic        obs_mis_next;
  logic        obs_berr_next;
  logic [31:0] obs_d_next;
  logic [31:0] obs_pc_next;

  lsu_pipe #(.TIMEOUT(TMO), .CHECK_ALIGN(1'b1), .ADDR_W(32)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .valid_in                (valid_in),
    .opcode                  (opcode),
    .funct3                  (funct3),
    .pc_from_ex              (pc_from_ex),
    .b                       (b),
    .c                       (c),
    .rd_from_ex              (rd_from_ex),
    .data_mem_access_ready_n (data_mem_access_ready_n),
    .data_from_mem           (data_from_mem),
    .data_mem_addr           (data_mem_addr),
    .require_mem_access      (require_mem_access),
    .write                   (write),
    .size                    (size),
    .data_to_mem             (data_to_mem),
    .valid_to_wb             (valid_to_wb),
    .pc_to_wb                (pc_to_wb),
    .rd_to_wb                (rd_to_wb),
    .opcode_to_wb            (opcode_to_wb),
    .c_to_wb                 (c_to_wb),
    .d                       (d),
    .misaligned              (misaligned),
    .bus_err                 (bus_err),
    .stall                   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Present one instruction, hold it while stalled, play `waits` not-ready
  // cycles, and record what the DUT shows up to one cycle past retirement.
  task automatic do_access(input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] pc, input logic [31:0] bb,
                           input logic [31:0] cc, input logic [4:0] rd,
                           input int waits, input logic [31:0] mdata);
    bit done;
    bit seen_busy;
    done = 1'b0;
    seen_busy = 1'b0;
    obs_lat = 0;
    obs_stall_cnt = 0;
    obs_req_cnt = 0;
    obs_write = 1'b0;
    obs_size = 2'b11;
    obs_dtm = '0;
    obs_addr = '0;
    @(negedge clk);
    valid_in = 1'b1;
    opcode = op;
    funct3 = f3;
    pc_from_ex = pc;
    b = bb;
    c = cc;
    rd_from_ex = rd;
    data_mem_access_ready_n = 1'b1;
    data_from_mem = mdata;
    #1;
    if (stall === 1'b1) obs_stall_cnt++;
    if (require_mem_access === 1'b1) obs_req_cnt++;
    for (int k = 1; k <= 40; k++) begin
      if (!done) begin
        @(negedge clk);
        #1;
        if (valid_to_wb === 1'b1) begin
          done = 1'b1;
          obs_lat = k;
          valid_in = 1'b0;
          data_mem_access_ready_n = 1'b1;
          obs_pc = pc_to_wb;
          obs_rd = rd_to_wb;
          obs_op = opcode_to_wb;
          obs_c = c_to_wb;
          obs_d = d;
          obs_mis = misaligned;
          obs_berr = bus_err;
          if (require_mem_access === 1'b1) obs_req_cnt++;
        end else begin
          data_mem_access_ready_n = (k - 1 < waits) ? 1'b1 : 1'b0;
          #1;
          if (stall === 1'b1) obs_stall_cnt++;
          if (require_mem_access === 1'b1) obs_req_cnt++;
          if (!seen_busy && require_mem_access === 1'b1) begin
            seen_busy = 1'b1;
            obs_write = write;
            obs_size = size;
            obs_dtm = data_to_mem;
            obs_addr = data_mem_addr;
          end
        end
      end
    end
    valid_in = 1'b0;
    @(negedge clk);
    #1;
    obs_v_next = valid_to_wb;
    obs_mis_next = misaligned;
    obs_berr_next = bus_err;
    obs_d_next = d;
    obs_pc_next = pc_to_wb;
    if (require_mem_access === 1'b1) obs_req_cnt++;
    if (stall === 1'b1) obs_stall_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid_in = 1'b1;
    opcode = OP_LOAD;
    funct3 = 3'b010;
    pc_from_ex = 32'h40;
    b = 32'hFFFF_FFFF;
    c = 32'h1000;
    rd_from_ex = 5'd9;
    data_mem_access_ready_n = 1'b0;
    data_from_mem = 32'h1234_5678;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({require_mem_access, stall, valid_to_wb, misaligned, bus_err, write} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b stall=%b v=%b mis=%b berr=%b wr=%b exp all 0",
               require_mem_access, stall, valid_to_wb, misaligned, bus_err, write);
    end
    checks++;
    if ({d, pc_to_wb, c_to_wb, data_to_mem, data_mem_addr} !== 160'd0 ||
        {size, rd_to_wb, opcode_to_wb} !== 14'd0) begin
      errors++;
      $display("FAIL reset_data got d=%h pc=%h c=%h dtm=%h addr=%h exp 0", d, pc_to_wb, c_to_wb, data_to_mem, data_mem_addr);
    end
    valid_in = 1'b0;
    data_mem_access_ready_n = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (valid_to_wb !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_valid got %b exp 0", valid_to_wb);
    end
  endtask

  task automatic test_passthrough();
    do_access(OP_ADD, 3'b000, 32'h100, 32'h0, 32'h55, 5'd3, 0, 32'h0);
    checks++;
    if (obs_lat !== 1 || obs_c !== 32'h55 || obs_pc !== 32'h100 || obs_rd !== 5'd3 || obs_op !== OP_ADD) begin
      errors++;
      $display("FAIL add_retire got lat=%0d c=%h pc=%h rd=%0d op=%b exp lat=1 c=55 pc=100 rd=3", obs_lat, obs_c, obs_pc, obs_rd, obs_op);
    end
    checks++;
    if (obs_stall_cnt !== 0 || obs_req_cnt !== 0) begin
      errors++;
      $display("FAIL add_nostall got stall=%0d req=%0d exp 0 0", obs_stall_cnt, obs_req_cnt);
    end
    checks++;
    if (obs_v_next !== 1'b0 || obs_mis !== 1'b0 || obs_berr !== 1'b0 || obs_pc_next !== 32'h100) begin
      errors++;
      $display("FAIL add_pulse got vnext=%b mis=%b berr=%b pcnext=%h exp 0 0 0 100", obs_v_next, obs_mis, obs_berr, obs_pc_next);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev_c;
    logic [31:0] prev_pc;
    logic [31:0] nc;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      #1;
      if (i > 0) begin
        checks++;
        if (valid_to_wb !== 1'b1 || c_to_wb !== prev_c || pc_to_wb !== prev_pc) begin
          errors++;
          $display("FAIL b2b_retire[%0d] got v=%b c=%h pc=%h exp 1 %h %h", i, valid_to_wb, c_to_wb, pc_to_wb, prev_c, prev_pc);
        end
      end
      if (i < 16) begin
        nc = $urandom;
        prev_c = nc;
        prev_pc = 32'h800 + 32'(i * 4);
        valid_in = 1'b1;
        opcode = 7'b0010011;
        funct3 = 3'($urandom_range(0, 7));
        pc_from_ex = prev_pc;
        c = nc;
        rd_from_ex = 5'($urandom_range(0, 31));
        #1;
        checks++;
        if (stall !== 1'b0) begin
          errors++;
          $display("FAIL b2b_stall[%0d] got %b exp 0", i, stall);
        end
      end else begin
        valid_in = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (valid_to_wb !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got v=%b exp 0", valid_to_wb);
    end
  endtask

  task automatic test_load_byte();
    do_access(OP_LOAD, 3'b000, 32'h200, 32'h0, 32'h2003, 5'd7, 0, 32'h80FF_FFFF);
    checks++;
    if (obs_lat !== 2 || obs_d !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_data got lat=%0d d=%h exp 2 ffffff80", obs_lat, obs_d);
    end
    checks++;
    if (obs_size !== 2'b10 || obs_write !== 1'b0 || obs_addr !== 32'h2003) begin
      errors++;
      $display("FAIL lb_bus got size=%b wr=%b addr=%h exp 10 0 2003", obs_size, obs_write, obs_addr);
    end
    checks++;
    if (obs_req_cnt !== 1 || obs_stall_cnt !== 2 || obs_v_next !== 1'b0 || obs_d_next !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_ctrl got req=%0d stall=%0d vnext=%b dnext=%h exp 1 2 0 ffffff80", obs_req_cnt, obs_stall_cnt, obs_v_next, obs_d_next);
    end
  endtask

  task automatic test_store_half();
    do_access(OP_STORE, 3'b001, 32'h204, 32'h1234_ABCD, 32'h2002, 5'd0, 3, 32'hDEAD_BEEF);
    checks++;
    if (obs_write !== 1'b1 || obs_size !== 2'b01 || obs_dtm !== 32'hABCD_ABCD || obs_addr !== 32'h2002) begin
      errors++;
      $display("FAIL sh_bus got wr=%b size=%b dtm=%h addr=%h exp 1 01 abcdabcd 2002", obs_write, obs_size, obs_dtm, obs_addr);
    end
    checks++;
    if (obs_stall_cnt !== 5 || obs_lat !== 5 || obs_req_cnt !== 4) begin
      errors++;
      $display("FAIL sh_timing got stall=%0d lat=%0d req=%0d exp 5 5 4", obs_stall_cnt, obs_lat, obs_req_cnt);
    end
    checks++;
    if (obs_d !== 32'hFFFF_FF80 || obs_berr !== 1'b0 || obs_pc !== 32'h204) begin
      errors++;
      $display("FAIL sh_retire got d=%h berr=%b pc=%h exp ffffff80 0 204", obs_d, obs_berr, obs_pc);
    end
  endtask

  task automatic test_misaligned();
    do_access(OP_LOAD, 3'b010, 32'h208, 32'h0, 32'h2001, 5'd4, 0, 32'h5555_5555);
    checks++;
    if (obs_lat !== 1 || obs_mis !== 1'b1 || obs_d !== 32'h0 || obs_berr !== 1'b0) begin
      errors++;
      $display("FAIL lw_mis got lat=%0d mis=%b d=%h berr=%b exp 1 1 0 0", obs_lat, obs_mis, obs_d, obs_berr);
    end
    checks++;
    if (obs_req_cnt !== 0 || obs_stall_cnt !== 0 || obs_mis_next !== 1'b0) begin
      errors++;
      $display("FAIL lw_mis_ctrl got req=%0d stall=%0d misnext=%b exp 0 0 0", obs_req_cnt, obs_stall_cnt, obs_mis_next);
    end
  endtask

  task automatic test_timeout();
    do_access(OP_LOAD, 3'b010, 32'h20C, 32'h0, 32'h3000, 5'd5, 0, 32'hCAFE_F00D);
    checks++;
    if (obs_d !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL lw_seed got d=%h exp cafef00d", obs_d);
    end
    do_access(OP_LOAD, 3'b101, 32'h210, 32'h0, 32'h3002, 5'd6, 20, 32'h1111_2222);
    checks++;
    if (obs_lat !== 5 || obs_berr !== 1'b1 || obs_d !== 32'h0 || obs_mis !== 1'b0) begin
      errors++;
      $display("FAIL lhu_timeout got lat=%0d berr=%b d=%h mis=%b exp 5 1 0 0", obs_lat, obs_berr, obs_d, obs_mis);
    end
    checks++;
    if (obs_req_cnt !== 4 || obs_berr_next !== 1'b0 || obs_v_next !== 1'b0) begin
      errors++;
      $display("FAIL lhu_timeout_ctrl got req=%0d berrnext=%b vnext=%b exp 4 0 0", obs_req_cnt, obs_berr_next, obs_v_next);
    end
    do_access(OP_LOAD, 3'b010, 32'h214, 32'h0, 32'h3004, 5'd2, TMO - 1, 32'h0BAD_CAFE);
    checks++;
    if (obs_lat !== 5 || obs_berr !== 1'b0 || obs_d !== 32'h0BAD_CAFE) begin
      errors++;
      $display("FAIL ready_at_timeout got lat=%0d berr=%b d=%h exp 5 0 0badcafe", obs_lat, obs_berr, obs_d);
    end
  endtask

  task automatic test_reset_busy();
    bit seen;
    logic [31:0] md;
    seen = 1'b0;
    @(negedge clk);
    valid_in = 1'b1;
    opcode = OP_LOAD;
    funct3 = 3'b010;
    pc_from_ex = 32'h300;
    c = 32'h4000;
    rd_from_ex = 5'd11;
    data_mem_access_ready_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (require_mem_access !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL rstbusy_enter got req=%b stall=%b exp 1 1", require_mem_access, stall);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (require_mem_access !== 1'b0 || stall !== 1'b0 || valid_to_wb !== 1'b0 || d !== 32'h0) begin
      errors++;
      $display("FAIL rstbusy_abort got req=%b stall=%b v=%b d=%h exp 0 0 0 0", require_mem_access, stall, valid_to_wb, d);
    end
    valid_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (valid_to_wb !== 1'b0 || bus_err !== 1'b0) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (valid_to_wb !== 1'b0 || bus_err !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstbusy_noretire got retire/bus_err seen=%b exp 0", seen);
    end
    md = $urandom;
    do_access(OP_LOAD, 3'b010, 32'h304, 32'h0, 32'h4008, 5'd12, 1, md);
    checks++;
    if (obs_lat !== 3 || obs_d !== md || obs_berr !== 1'b0 || obs_pc !== 32'h304 || obs_rd !== 5'd12) begin
      errors++;
      $display("FAIL rstbusy_next_lw got lat=%0d d=%h berr=%b pc=%h exp 3 %h 0 304", obs_lat, obs_d, obs_berr, obs_pc, md);
    end
  endtask

  // Randomized traffic against a model built from the access rules
  task automatic test_random();
    logic [6:0]  pass_ops [5];
    logic [2:0]  ld_f3 [5];
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc, bb, cc, md, val, exp_dtm, model_d;
    logic [4:0]  rd;
    logic [1:0]  exp_size;
    int kind, waits, nbytes, busy, exp_lat, exp_stall;
    bit is_mem, mis, berr;
    pass_ops[0] = 7'b0110011; pass_ops[1] = 7'b0010011; pass_ops[2] = 7'b1101111;
    pass_ops[3] = 7'b0110111; pass_ops[4] = 7'b1100011;
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
    do_access(OP_LOAD, 3'b010, 32'h500, 32'h0, 32'h6000, 5'd1, 0, 32'h7654_3210);
    model_d = 32'h7654_3210;
    checks++;
    if (obs_d !== model_d) begin
      errors++;
      $display("FAIL rnd_seed got d=%h exp %h", obs_d, model_d);
    end
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 2);
      pc = $urandom & 32'hFFFF_FFFC;
      bb = $urandom;
      cc = $urandom;
      md = $urandom;
      rd = 5'($urandom_range(0, 31));
      waits = $urandom_range(0, 5);
      if (kind == 0) begin
        op = pass_ops[$urandom_range(0, 4)];
        f3 = 3'($urandom_range(0, 7));
      end else if (kind == 1) begin
        op = OP_LOAD;
        f3 = ld_f3[$urandom_range(0, 4)];
      end else begin
        op = OP_STORE;
        f3 = 3'($urandom_range(0, 2));
      end
      nbytes = 1 << int'(f3 % 4);
      if (kind != 0 && $urandom_range(0, 3) != 0) cc = cc - (cc % 32'(nbytes));
      is_mem = (kind != 0);
      mis = is_mem && ((cc % 32'(nbytes)) != 0);
      busy = (is_mem && !mis) ? ((waits + 1 < TMO) ? waits + 1 : TMO) : 0;
      berr = is_mem && !mis && (waits >= TMO);
      exp_lat = 1 + busy;
      exp_stall = (busy > 0) ? busy + 1 : 0;
      exp_size = (nbytes == 1) ? 2'b10 : ((nbytes == 2) ? 2'b01 : 2'b00);
      exp_dtm = (nbytes == 1) ? (bb % 256) * 32'h0101_0101 :
                ((nbytes == 2) ? (bb % 65536) * 32'h0001_0001 : bb);
      if (mis || berr) begin
        model_d = 32'h0;
      end else if (kind == 1) begin
        val = md >> (8 * (cc % 4));
        if (nbytes == 1) begin
          model_d = val % 256;
          if (f3 == 3'b000 && model_d >= 128) model_d = model_d + 32'hFFFF_FF00;
        end else if (nbytes == 2) begin
          model_d = val % 65536;
          if (f3 == 3'b001 && model_d >= 32768) model_d = model_d + 32'hFFFF_0000;
        end else begin
          model_d = val;
        end
      end
      do_access(op, f3, pc, bb, cc, rd, waits, md);
      checks++;
      if (obs_lat !== exp_lat || obs_stall_cnt !== exp_stall || obs_req_cnt !== busy || obs_v_next !== 1'b0) begin
        errors++;
        $display("FAIL rnd_timing[%0d] got lat=%0d stall=%0d req=%0d vnext=%b exp %0d %0d %0d 0",
                 it, obs_lat, obs_stall_cnt, obs_req_cnt, obs_v_next, exp_lat, exp_stall, busy);
      end
      checks++;
      if (obs_pc !== pc || obs_rd !== rd || obs_op !== op || obs_c !== cc || obs_d !== model_d ||
          obs_mis !== mis || obs_berr !== berr) begin
        errors++;
        $display("FAIL rnd_retire[%0d] got pc=%h rd=%0d op=%b c=%h d=%h mis=%b berr=%b exp %h %0d %b %h %h %b %b",
                 it, obs_pc, obs_rd, obs_op, obs_c, obs_d, obs_mis, obs_berr, pc, rd, op, cc, model_d, mis, berr);
      end
      if (busy > 0) begin
        checks++;
        if (obs_write !== (kind == 2) || obs_size !== exp_size || obs_addr !== cc ||
            (kind == 2 && obs_dtm !== exp_dtm)) begin
          errors++;
          $display("FAIL rnd_bus[%0d] got wr=%b size=%b addr=%h dtm=%h exp %b %b %h %h",
                   it, obs_write, obs_size, obs_addr, obs_dtm, (kind == 2), exp_size, cc, exp_dtm);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    valid_in = 1'b0;
    opcode = '0;
    funct3 = '0;
    pc_from_ex = '0;
    b = '0;
    c = '0;
    rd_from_ex = '0;
    data_mem_access_ready_n = 1'b1;
    data_from_mem = '0;
    rst_n = 1'b0;
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_pipe.md
LSU_PIPE -- requirements
Module: lsu_pipe

Interface
REQ-001 Parameter TIMEOUT, default 16: number of not-ready wait cycles after which an access is aborted; legal range 1..255.
REQ-002 Parameter CHECK_ALIGN, default 1: 1 = misaligned half/word accesses are trapped; 0 = the address is issued unchanged.
REQ-003 Parameter ADDR_W, default 32: width of data_mem_addr, which carries c[ADDR_W-1:0].
REQ-004 Clock and reset are fixed:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-005 EX-side inputs:
- valid_in  in  1  EX presents an instruction.
- opcode  in  7  instruction opcode.
- funct3  in  3  load/store format.
- pc_from_ex  in  32  instruction PC.
- b  in  32  store data.
- c  in  32  effective address or ALU result.
- rd_from_ex  in  5  destination register.
REQ-006 Memory-side inputs:
- data_mem_access_ready_n  in  1  0 = access completes this cycle.
- data_from_mem  in  32  read data.
REQ-007 Memory-side outputs:
- data_mem_addr  out  ADDR_W  access address.
- require_mem_access  out  1  access request.
- write  out  1  1 = store.
- size  out  2  00 word, 01 half, 10 byte.
- data_to_mem  out  32  store data.
REQ-008 WB- and EX-side outputs:
- valid_to_wb  out  1  WB registers hold a retired instruction.
- pc_to_wb  out  32  retired PC.
- rd_to_wb  out  5  retired destination register.
- opcode_to_wb  out  7  retired opcode.
- c_to_wb  out  32  retired ALU result.
- d  out  32  loaded data.
- misaligned  out  1  misaligned-access exception.
- bus_err  out  1  access timed out.
- stall  out  1  EX must hold its inputs.

Function
REQ-009 A load is opcode 0000011, a store is 0100011, and every other opcode is a pass-through.
REQ-010 The FSM has two states: IDLE and BUSY.
REQ-011 In IDLE with valid_in=1, the block captures opcode, funct3, pc, b, c and rd into internal registers.
REQ-012 An accepted pass-through, or (with CHECK_ALIGN=1) an accepted misaligned access, retires on the next edge with valid_to_wb=1 and the FSM stays in IDLE.
REQ-013 A misaligned access is a half access with c[0]=1, or a word access with c[1:0]!=00.
REQ-014 A misaligned access does not assert require_mem_access; it retires with misaligned=1 and d=0.
REQ-015 An aligned load or store moves IDLE->BUSY and clears the wait counter.
REQ-016 In BUSY, require_mem_access=1 and data_mem_addr, write, size and data_to_mem are driven from the captured registers.
REQ-017 In IDLE, require_mem_access=0 and the other memory outputs are don't-care.
REQ-018 In BUSY with data_mem_access_ready_n=0, the access completes:
- a load registers the converted data into d;
- the instruction retires with valid_to_wb=1;
- the FSM returns to IDLE.
REQ-019 In BUSY with data_mem_access_ready_n=1, the wait counter increments.
REQ-020 When the counter reaches TIMEOUT, the access is aborted: retire with bus_err=1, d=0, FSM to IDLE.
REQ-021 Ready arriving in the same cycle as the timeout wins: the access completes normally.
REQ-022 stall=1 in BUSY, and also combinationally in IDLE when an aligned load/store is being accepted.
REQ-023 EX holds its inputs stable while stall=1, and no new instruction is accepted while the FSM is in BUSY.
REQ-024 valid_to_wb is a one-cycle pulse per retired instruction.
REQ-025 The WB outputs hold their values between retirements.
REQ-026 misaligned and bus_err are valid only together with valid_to_wb and are 0 otherwise.
REQ-027 The size encoding follows funct3[1:0]: 00 gives 10 (byte), 01 gives 01 (half), 10 gives 00 (word).
REQ-028 Store data is replicated across lanes:
- byte: {4{b[7:0]}};
- half: {2{b[15:0]}};
- word: b.
REQ-029 Load data is first shifted right by 8*c[1:0], then extended by funct3:
- 000 sign-extends a byte; 100 zero-extends a byte;
- 001 sign-extends a half; 101 zero-extends a half;
- 010 passes the word unchanged.
REQ-030 Latency: pass-through and misaligned instructions take 1 cycle.
REQ-031 Latency: a memory access takes 1 + (BUSY cycles up to and including the ready cycle).
REQ-032 Back-to-back pass-throughs sustain one instruction per cycle.

Reset
REQ-033 While rst_n=0, all registers clear asynchronously: FSM to IDLE, wait counter 0, and every output 0 (including require_mem_access, stall and valid_to_wb).
REQ-034 rst_n asserted while in BUSY aborts the access: no retirement and no bus_err.
REQ-035 The first acceptance after reset is on the first rising edge with rst_n=1 and valid_in=1.

Verification
REQ-036 Bench: ADD pass-through, pc=0x100, c=0x55 -> next cycle valid_to_wb=1, c_to_wb=0x55, stall never asserted.
REQ-037 Bench: LB, c=0x2003, ready_n=0 in the first BUSY cycle, data_from_mem=0x80FFFFFF -> d=0xFFFFFF80 two cycles after acceptance, size=10.
REQ-038 Bench: SH, c=0x2002, b=0x1234ABCD, ready_n=1 for 3 cycles then 0 -> write=1, size=01, data_to_mem=0xABCDABCD, stall=1 for 5 cycles.
REQ-039 Bench: LW, c=0x2001, CHECK_ALIGN=1 -> require_mem_access never asserted, retire with misaligned=1, d=0.
REQ-040 Bench: LHU with ready_n held at 1, TIMEOUT=4 -> bus_err=1 on the retirement after 4 wait cycles, FSM back to IDLE.
REQ-041 Bench: rst_n pulsed low during BUSY -> require_mem_access=0 immediately, no valid_to_wb pulse, the next LW completes normally.
